btn_debounce_pulse: RTL
=======================

Name: btn_debounce_pulse

Overview:
- Cleans one raw, asynchronous push-button input (a ui_in pin) into a stable debounced level plus single-cycle press/release pulses.
- Sits directly upstream of the counter core; press_pulse drives the counter's step/enable input.
- Also removes metastability and bounce so the counter advances exactly once per physical press.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronized samples required to accept a level change (min 2).
- CNT_W, 8: stability/repeat counter width; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- REPEAT_DELAY, 64: cycles held in PRESSED before the first auto-repeat pulse (feature only).
- REPEAT_PERIOD, 16: cycles between subsequent auto-repeat pulses (feature only).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design enable; 0 freezes FSM and counters.
- btn_in  in  1  raw asynchronous button, active-high.
- btn_level  out  1  debounced level; 1 in PRESSED/RELEASE_WAIT.
- press_pulse  out  1  one-cycle pulse on accepted press (and auto-repeats).
- release_pulse  out  1  one-cycle pulse on accepted release.
- busy  out  1  1 in PRESS_WAIT or RELEASE_WAIT.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: synchronizer flops=0, state=IDLE, cnt=0, all outputs 0. Reset wins over every other event, including mid-wait and mid-pulse.
- Synchronizer: 2 flops (ff1, sync_q), always running, including when ena=0.
- States:
  - IDLE: btn_level=0. sync_q=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: sync_q=1 and cnt<STABLE_CYCLES-1 -> cnt+1. sync_q=1 and cnt==STABLE_CYCLES-1 -> PRESSED, press_pulse<=1, cnt<=0. sync_q=0 -> IDLE, cnt<=0, no pulse.
  - PRESSED: btn_level=1. sync_q=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: btn_level stays 1. Same counting rule as PRESS_WAIT on sync_q=0; on completion -> IDLE, release_pulse<=1. sync_q=1 -> PRESSED with no pulse.
- Latency: sampling edge of btn_in high = edge 0. sync_q=1 after edge 1; PRESS_WAIT after edge 2; press_pulse high after edge STABLE_CYCLES+2 for exactly 1 cycle. Release is symmetric.
- All outputs are registered. Pulses self-clear the next cycle.
- ena=0: state, cnt and btn_level held; press_pulse/release_pulse forced 0. A pulse due on that edge is lost, not deferred. Counting resumes from the held cnt when ena returns to 1.
- cnt never wraps: it saturates at its compare value and is cleared on every state change.
- press_pulse and release_pulse are never high in the same cycle.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: in PRESSED, cnt counts each enabled cycle.
  - At cnt==REPEAT_DELAY-1: press_pulse<=1, cnt<=0, and the delay phase ends.
  - After that, a pulse every REPEAT_PERIOD cycles while the button is held (internal 1-bit phase flag, cleared on leaving PRESSED).
  - Entering RELEASE_WAIT stops repeats. A bounce back to PRESSED restarts the REPEAT_DELAY phase.
- Undefined: exactly one press_pulse per accepted press; PRESSED does not count.

Decomposition:
- Package btn_pkg: state encoding localparams ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3, plus default parameter constants.
- Sub-module sync_2ff: 2-flop synchronizer with synchronous active-high reset, reusable for other ui_in pins.
- FSM, counter and repeat logic stay in btn_debounce_pulse.

Test Plan (STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Reset then clean press at edge 0 -> press_pulse=1 for exactly the cycle after edge 6; btn_level=1 from the same edge; busy=1 after edges 2..5.
- Press bouncing 1,0,1,0 on alternate cycles, then steady 1 -> no pulse during bounce; one press_pulse 6 edges after the last rising sample.
- Held press, then release glitch of 2 cycles -> returns to PRESSED, no release_pulse, btn_level stays 1. Clean release -> release_pulse once, btn_level=0.
- ena=0 asserted while in PRESS_WAIT with cnt=2 for 5 cycles -> no pulse, cnt holds 2; after ena=1, press_pulse 2 edges later.
- rst=1 one cycle while PRESSED with press_pulse high -> the next edge has all outputs 0 and state IDLE; with btn still high, a fresh press_pulse follows 6 edges after rst deasserts.
- BTN_AUTO_REPEAT_EN defined, hold 30 cycles -> pulses at press, +8, +12, +16, ...; none after release. Macro undefined -> single pulse only.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared state encoding and default timing constants for push-button conditioning.
// Latency: none (declarations only). Backpressure: not applicable.
package btn_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE         = 2'd0;
    localparam state_t ST_PRESS_WAIT   = 2'd1;
    localparam state_t ST_PRESSED      = 2'd2;
    localparam state_t ST_RELEASE_WAIT = 2'd3;

    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_REPEAT_DELAY  = 64;
    localparam int DEF_REPEAT_PERIOD = 16;

    function automatic logic is_wait_state(input state_t st);
        return (st == ST_PRESS_WAIT) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous ui_in pins; free-running, ignores design enable.
// Latency: 2 clk edges from input sample to q_o. Backpressure: none.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] ff1_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_q  <= '0;
            sync_q <= '0;
        end else begin
            ff1_q  <= d_i;
            sync_q <= ff1_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces one raw button into a level plus press/release pulses; BTN_AUTO_REPEAT_EN adds held-key repeats.
// Latency: press_pulse STABLE_CYCLES+2 edges after the first high sample. Backpressure: none; ena=0 freezes.
import btn_pkg::*;

module btn_debounce_pulse #(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             cnt_done_d;
    logic             btn_level_q;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             busy_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (sync_q)
    );

    assign cnt_inc_d  = cnt_q + 1'b1;
    assign cnt_done_d = (cnt_q == STABLE_LAST);

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // phase_q=0: waiting out the initial delay; phase_q=1: periodic repeats.
    logic             phase_q;
    logic [CNT_W-1:0] rep_last_d;

    assign rep_last_d = phase_q ? PERIOD_LAST : DELAY_LAST;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            busy_q          <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            phase_q         <= 1'b0;
`endif
        end else if (!ena) begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync_q) begin
                        state_q <= ST_PRESS_WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync_q) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_done_d) begin
                        state_q       <= ST_PRESSED;
                        cnt_q         <= '0;
                        busy_q        <= 1'b0;
                        btn_level_q   <= 1'b1;
                        press_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_PRESSED: begin
                    if (!sync_q) begin
                        state_q <= ST_RELEASE_WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        phase_q <= 1'b0;
                    end else if (cnt_q == rep_last_d) begin
                        press_pulse_q <= 1'b1;
                        cnt_q         <= '0;
                        phase_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A bounce back high returns to PRESSED silently; level never dropped.
                    if (sync_q) begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_done_d) begin
                        state_q         <= ST_IDLE;
                        cnt_q           <= '0;
                        busy_q          <= 1'b0;
                        btn_level_q     <= 1'b0;
                        release_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    btn_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign busy          = busy_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(press_pulse_q && release_pulse_q));
            assert (busy_q == is_wait_state(state_q));
        end
    end
`endif

endmodule
